// File: rtl/hs_arith_uequal_splitter_seq.sv
// Sequential equal-share splitter: divides a total by the constant OUTPUT_NUM
// with a bit-serial restoring divider and spreads the remainder over the lowest shares.
module hs_arith_uequal_splitter_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int OUTPUT_NUM = 16,
    localparam int LOG_N = $clog2(OUTPUT_NUM),
    // Closed form of $clog2(OUTPUT_NUM*(2**DATA_WIDTH-1)+1) that stays in 32-bit arithmetic
    localparam int IN_WIDTH =
        (DATA_WIDTH >= LOG_N ||
         ((1 << DATA_WIDTH) * (OUTPUT_NUM - (1 << (LOG_N - 1)))) > (OUTPUT_NUM - 1))
        ? DATA_WIDTH + LOG_N : DATA_WIDTH + LOG_N - 1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   din,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] dout [OUTPUT_NUM],
    output logic                  out_err
);

    localparam logic [DATA_WIDTH-1:0] EACH_OUTPUT_MAX = '1;
    localparam logic [IN_WIDTH-1:0]   INPUT_MAX = IN_WIDTH'(OUTPUT_NUM) * IN_WIDTH'(EACH_OUTPUT_MAX);
    localparam int                    REM_W     = LOG_N + 1;
    localparam int                    CNT_W     = $clog2(IN_WIDTH + 1);
    localparam logic [REM_W-1:0]      DIVISOR   = REM_W'(OUTPUT_NUM);
    localparam logic [CNT_W-1:0]      LAST_STEP = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t                state;
    state_t                state_next;
    logic [IN_WIDTH-1:0]   shreg;
    logic [IN_WIDTH-1:0]   shreg_next;
    logic [REM_W-1:0]      rem;
    logic [REM_W-1:0]      rem_next;
    logic [REM_W-1:0]      trial;
    logic [CNT_W-1:0]      step_cnt;
    logic                  err;
    logic                  accept;
    logic                  out_fire;
    logic                  last_step;
    logic [DATA_WIDTH-1:0] share_next [OUTPUT_NUM];

    assign in_ready  = (state == IDLE) & ce;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & ce;
    assign last_step = (state == DIV) && (step_cnt == LAST_STEP);

    // One restoring step: quotient bits shift into the LSB as the dividend shifts out the MSB
    always_comb begin
        trial = {rem[REM_W-2:0], shreg[IN_WIDTH-1]};
        if (trial >= DIVISOR) begin
            rem_next   = trial - DIVISOR;
            shreg_next = {shreg[IN_WIDTH-2:0], 1'b1};
        end else begin
            rem_next   = trial;
            shreg_next = {shreg[IN_WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        for (int i = 0; i < OUTPUT_NUM; i++) begin
            if (err) begin
                share_next[i] = EACH_OUTPUT_MAX;
            end else begin
                share_next[i] = shreg_next[DATA_WIDTH-1:0]
                              + DATA_WIDTH'(REM_W'(i) < rem_next);
            end
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else if (ce) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = DIV;
            DIV:     if (last_step) state_next = DONE;
            DONE:    if (out_fire)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shares and out_err only change on the final divider step, so they hold through DONE and IDLE
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            shreg    <= '0;
            rem      <= '0;
            step_cnt <= '0;
            err      <= 1'b0;
            out_err  <= 1'b0;
            for (int i = 0; i < OUTPUT_NUM; i++) begin
                dout[i] <= '0;
            end
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= din;
                        rem      <= '0;
                        step_cnt <= '0;
                        err      <= (din > INPUT_MAX);
                    end
                end
                DIV: begin
                    shreg    <= shreg_next;
                    rem      <= rem_next;
                    step_cnt <= step_cnt + CNT_W'(1);
                    if (last_step) begin
                        out_err <= err;
                        for (int i = 0; i < OUTPUT_NUM; i++) begin
                            dout[i] <= share_next[i];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_arith_uequal_splitter_seq.sv
// Directed bench for the equal-share splitter: a default 16-way instance and a 3-way instance.
module tb_hs_arith_uequal_splitter_seq;

    logic       clk = 1'b0;
    logic       areset;

    logic       a_ce, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [11:0] a_din;
    logic [7:0] a_dout [16];

    logic       b_ce, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [9:0] b_din;
    logic [7:0] b_dout [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs_arith_uequal_splitter_seq #(.DATA_WIDTH(8), .OUTPUT_NUM(16)) dut_a (
        .clk(clk), .areset(areset), .ce(a_ce),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .din(a_din),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .dout(a_dout), .out_err(a_out_err)
    );

    hs_arith_uequal_splitter_seq #(.DATA_WIDTH(8), .OUTPUT_NUM(3)) dut_b (
        .clk(clk), .areset(areset), .ce(b_ce),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .din(b_din),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .dout(b_dout), .out_err(b_out_err)
    );

    // Reference share value for quotient q and remainder r
    function automatic logic [7:0] exp_share(input int q, input int r, input int i);
        return 8'(q + ((i < r) ? 1 : 0));
    endfunction

    task automatic accept_a(input logic [11:0] value);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_din      = value;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
    endtask

    task automatic wait_valid_a(output int edges);
        edges = 1;
        while (a_out_valid !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        int bad;
        areset = 1'b1;
        a_ce = 1'b1; a_in_valid = 1'b0; a_din = '0; a_out_ready = 1'b1;
        b_ce = 1'b1; b_in_valid = 1'b0; b_din = '0; b_out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", a_out_valid);
        end
        checks++;
        if (a_out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_err: got %b, expected 0", a_out_err);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_dout[i] !== 8'd0) begin
                bad++; $display("[TB] FAIL reset_dout[%0d]: got %0d, expected 0", i, a_dout[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_in_ready_ce1: got %b, expected 1", a_in_ready);
        end
        a_ce = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_in_ready_ce0: got %b, expected 0", a_in_ready);
        end
        a_ce = 1'b1;
        checks++;
        if (b_out_valid !== 1'b0 || b_out_err !== 1'b0 || b_dout[0] !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_b: got valid=%b err=%b dout0=%0d, expected 0 0 0",
                               b_out_valid, b_out_err, b_dout[0]);
        end
    endtask

    task automatic test_basic;
        int edges, bad, sum;
        accept_a(12'd37);
        wait_valid_a(edges);
        checks++;
        if (edges != 13) begin
            errors++; $display("[TB] FAIL basic_latency: got %0d, expected 13", edges);
        end
        bad = 0; sum = 0;
        for (int i = 0; i < 16; i++) begin
            sum += a_dout[i];
            if (a_dout[i] !== exp_share(2, 5, i)) begin
                bad++; $display("[TB] FAIL basic_dout[%0d]: got %0d, expected %0d", i, a_dout[i], exp_share(2, 5, i));
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (sum != 37) begin
            errors++; $display("[TB] FAIL basic_sum: got %0d, expected 37", sum);
        end
        checks++;
        if (a_out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL basic_err: got %b, expected 0", a_out_err);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL basic_release: got valid=%b ready=%b, expected 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_back_to_back;
        int n, edges, bad, seen;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_din      = 12'd0;
        @(posedge clk);
        @(negedge clk);
        a_din = 12'd4080;
        n = 1; seen = 0;
        while (a_in_ready !== 1'b1 && n < 200) begin
            if (a_out_valid === 1'b1 && seen == 0) begin
                seen = 1;
                bad = 0;
                for (int i = 0; i < 16; i++) begin
                    if (a_dout[i] !== 8'd0) begin
                        bad++; $display("[TB] FAIL zero_dout[%0d]: got %0d, expected 0", i, a_dout[i]);
                    end
                end
                checks++;
                if (bad != 0 || a_out_err !== 1'b0) begin
                    errors++; $display("[TB] FAIL zero_result: got %0d bad shares err=%b, expected 0 bad err=0", bad, a_out_err);
                end
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("[TB] FAIL zero_valid_seen: got %0d, expected 1", seen);
        end
        checks++;
        if (n != 14) begin
            errors++; $display("[TB] FAIL initiation_interval: got %0d, expected 14", n);
        end
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        wait_valid_a(edges);
        checks++;
        if (edges != 13) begin
            errors++; $display("[TB] FAIL max_latency: got %0d, expected 13", edges);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_dout[i] !== 8'd255) begin
                bad++; $display("[TB] FAIL max_dout[%0d]: got %0d, expected 255", i, a_dout[i]);
            end
        end
        checks++;
        if (bad != 0 || a_out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL max_result: got %0d bad shares err=%b, expected 0 bad err=0", bad, a_out_err);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int edges, bad;
        accept_a(12'd4095);
        wait_valid_a(edges);
        checks++;
        if (edges != 13) begin
            errors++; $display("[TB] FAIL ovf_latency: got %0d, expected 13", edges);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_dout[i] !== 8'd255) begin
                bad++; $display("[TB] FAIL ovf_dout[%0d]: got %0d, expected 255", i, a_dout[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (a_out_err !== 1'b1) begin
            errors++; $display("[TB] FAIL ovf_err: got %b, expected 1", a_out_err);
        end
        @(negedge clk);
    endtask

    task automatic test_abort_reset;
        int edges, bad;
        accept_a(12'd1000);
        repeat (5) @(negedge clk);
        areset = 1'b1;
        #1;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_dout[i] !== 8'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("[TB] FAIL abort_dout: got %0d nonzero shares, expected 0", bad);
        end
        checks++;
        if (a_out_valid !== 1'b0 || a_out_err !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL abort_ctrl: got valid=%b err=%b ready=%b, expected 0 0 1",
                               a_out_valid, a_out_err, a_in_ready);
        end
        @(negedge clk);
        areset = 1'b0;
        accept_a(12'd16);
        wait_valid_a(edges);
        checks++;
        if (edges != 13) begin
            errors++; $display("[TB] FAIL abort_next_latency: got %0d, expected 13", edges);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_dout[i] !== 8'd1) begin
                bad++; $display("[TB] FAIL abort_next_dout[%0d]: got %0d, expected 1", i, a_dout[i]);
            end
        end
        checks++;
        if (bad != 0) errors++;
        @(negedge clk);
    endtask

    task automatic test_ce_stall;
        int edges, bad;
        accept_a(12'd1000);
        edges = 1;
        while (a_out_valid !== 1'b1 && edges < 200) begin
            if (edges == 4) a_ce = 1'b0;
            if (edges == 9) a_ce = 1'b1;
            @(negedge clk);
            edges++;
        end
        a_ce = 1'b1;
        checks++;
        if (edges != 18) begin
            errors++; $display("[TB] FAIL ce_latency: got %0d, expected 18", edges);
        end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (a_dout[i] !== exp_share(62, 8, i)) begin
                bad++; $display("[TB] FAIL ce_dout[%0d]: got %0d, expected %0d", i, a_dout[i], exp_share(62, 8, i));
            end
        end
        checks++;
        if (bad != 0 || a_out_err !== 1'b0) errors++;
        @(negedge clk);
    endtask

    task automatic test_small_n_stall;
        int edges, bad;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_din      = 10'd10;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        edges = 1;
        while (b_out_valid !== 1'b1 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        checks++;
        if (edges != 11) begin
            errors++; $display("[TB] FAIL n3_latency: got %0d, expected 11", edges);
        end
        checks++;
        if (b_dout[0] !== 8'd4 || b_dout[1] !== 8'd3 || b_dout[2] !== 8'd3 || b_out_err !== 1'b0) begin
            errors++; $display("[TB] FAIL n3_dout: got {%0d,%0d,%0d} err=%b, expected {4,3,3} err=0",
                               b_dout[0], b_dout[1], b_dout[2], b_out_err);
        end
        b_in_valid = 1'b1;
        b_din      = 10'd7;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (b_dout[0] !== 8'd4 || b_dout[1] !== 8'd3 || b_dout[2] !== 8'd3 ||
                b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
                errors++; bad++;
                $display("[TB] FAIL n3_hold cycle %0d: got {%0d,%0d,%0d} valid=%b ready=%b, expected {4,3,3} 1 0",
                         c, b_dout[0], b_dout[1], b_dout[2], b_out_valid, b_in_ready);
            end
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 ||
            b_dout[0] !== 8'd4 || b_dout[1] !== 8'd3 || b_dout[2] !== 8'd3) begin
            errors++; $display("[TB] FAIL n3_after_release: got {%0d,%0d,%0d} valid=%b ready=%b, expected {4,3,3} 0 1",
                               b_dout[0], b_dout[1], b_dout[2], b_out_valid, b_in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_abort_reset();
        test_ce_stall();
        test_small_n_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
